// File: rtl/a0_trace_fifo.sv
// Change-detect trace buffer for the CPU a0 register: every new a0 value is
// stamped with a free-running cycle count and queued in a show-ahead FIFO.
module a0_trace_fifo #(
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 32,
    parameter int DROP_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [31:0]                a0,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [TS_WIDTH-1:0]        out_ts,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [DROP_WIDTH-1:0]      drop_cnt,
    input  logic                       clr_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [31:0]           prev_a0_q, prev_a0_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic [31:0]           data_mem_q [DEPTH];
    logic [TS_WIDTH-1:0]   ts_mem_q   [DEPTH];

    logic event_w;
    logic full_w;
    logic pop_w;
    logic push_w;
    logic drop_w;

    assign event_w = en && (a0 != prev_a0_q);
    assign full_w  = (count_q == FULL_CNT);
    assign pop_w   = out_valid && out_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign push_w  = event_w && (!full_w || pop_w);
    assign drop_w  = event_w && full_w && !pop_w;

    always_comb begin
        ts_d       = ts_q + TS_WIDTH'(1);
        prev_a0_d  = a0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push_w) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_w && !pop_w) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_w && !push_w) begin
            count_d = count_q - CNT_W'(1);
        end

        // A drop coinciding with a clear is counted as the first drop after it.
        if (clr_ovf) begin
            overflow_d = drop_w;
            drop_cnt_d = drop_w ? DROP_WIDTH'(1) : '0;
        end else if (drop_w) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_q       <= '0;
            prev_a0_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            prev_a0_q  <= prev_a0_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is left unreset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (rst && push_w) begin
            data_mem_q[wr_ptr_q] <= a0;
            ts_mem_q[wr_ptr_q]   <= ts_q;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? data_mem_q[rd_ptr_q] : '0;
    assign out_ts    = out_valid ? ts_mem_q[rd_ptr_q]   : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Directed bench for a0_trace_fifo built with DEPTH=4, TS_WIDTH=4, DROP_WIDTH=2
// so that full, timestamp wrap and drop-counter saturation are reachable quickly.
module tb_a0_trace_fifo;

    localparam int DEPTH      = 4;
    localparam int TS_WIDTH   = 4;
    localparam int DROP_WIDTH = 2;

    logic                    clk;
    logic                    rst;
    logic                    en;
    logic [31:0]             a0;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_data;
    logic [TS_WIDTH-1:0]     out_ts;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;
    logic [DROP_WIDTH-1:0]   drop_cnt;
    logic                    clr_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    a0_trace_fifo #(
        .DEPTH      (DEPTH),
        .TS_WIDTH   (TS_WIDTH),
        .DROP_WIDTH (DROP_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a0        (a0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        en        = 1'b1;
        a0        = 32'h0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b required 0", out_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b required 0", overflow); end
        n_checks++; if (drop_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_drop: got %0d required 0", drop_cnt); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", out_data); end
        n_checks++; if (out_ts !== 4'h0) begin n_fail++; $display("FAIL reset_ts: got %0d required 0", out_ts); end
        $display("test_reset: valid=%0b count=%0d ovf=%0b", out_valid, count, overflow);
    endtask

    task automatic test_no_change();
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %0b required 0", out_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL idle_count: got %0d required 0", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL idle_ovf: got %0b required 0", overflow); end
        // changes with en=0 are ignored, but prev_a0 still tracks them
        en = 1'b0; a0 = 32'h33; tick();
        a0 = 32'h44; tick();
        en = 1'b1; tick();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL en_off_count: got %0d required 0", count); end
        n_checks++; if (drop_cnt !== 2'd0) begin n_fail++; $display("FAIL en_off_drop: got %0d required 0", drop_cnt); end
        $display("test_no_change: count=%0d drop=%0d", count, drop_cnt);
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        a0 = 32'hFF; tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b required 1", out_valid); end
        n_checks++; if (out_data !== 32'hFF) begin n_fail++; $display("FAIL single_data: got %h required ff", out_data); end
        n_checks++; if (out_ts !== 4'd5) begin n_fail++; $display("FAIL single_ts: got %0d required 5", out_ts); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d required 1", count); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_data !== 32'hFF || out_ts !== 4'd5 || count !== 3'd1)
                begin n_fail++; $display("FAIL hold_stable: got data=%h ts=%0d count=%0d required ff/5/1", out_data, out_ts, count); end
        end
        out_ready = 1'b1; tick();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL pop_count: got %0d required 0", count); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL empty_data: got %h required 0", out_data); end
        tick();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL empty_ready_count: got %0d required 0", count); end
        out_ready = 1'b0;
        $display("test_single: popped 0xff ts=5, count=%0d", count);
    endtask

    task automatic test_overflow();
        logic [31:0] exp_data [4];
        logic [3:0]  exp_ts   [4];
        exp_data = '{32'd2, 32'd3, 32'd4, 32'd9};
        exp_ts   = '{4'd1, 4'd2, 4'd3, 4'd6};
        do_reset();
        for (int i = 1; i <= 6; i++) begin a0 = 32'(i); tick(); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d required 4", count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b required 1", overflow); end
        n_checks++; if (drop_cnt !== 2'd2) begin n_fail++; $display("FAIL ovf_drop: got %0d required 2", drop_cnt); end
        n_checks++; if (out_data !== 32'd1 || out_ts !== 4'd0)
            begin n_fail++; $display("FAIL ovf_head: got %h/%0d required 1/0", out_data, out_ts); end
        // full FIFO with a simultaneous pop accepts the new event
        out_ready = 1'b1; a0 = 32'd9; tick();
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fullpop_count: got %0d required 4", count); end
        n_checks++; if (drop_cnt !== 2'd2) begin n_fail++; $display("FAIL fullpop_drop: got %0d required 2", drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_data !== exp_data[i] || out_ts !== exp_ts[i])
                begin n_fail++; $display("FAIL drain_%0d: got %h/%0d required %h/%0d", i, out_data, out_ts, exp_data[i], exp_ts[i]); end
            $display("test_overflow: drain data=%h ts=%0d", out_data, out_ts);
            tick();
        end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_empty: got %0d required 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_clr();
        logic [1:0] exp_drop [4];
        exp_drop = '{2'd1, 2'd2, 2'd3, 2'd3};
        do_reset();
        for (int i = 1; i <= 6; i++) begin a0 = 32'(i); tick(); end
        a0 = 32'd7; clr_ovf = 1'b1; tick();
        n_checks++; if (overflow !== 1'b1 || drop_cnt !== 2'd1)
            begin n_fail++; $display("FAIL clr_with_drop: got ovf=%0b drop=%0d required 1/1", overflow, drop_cnt); end
        tick();
        n_checks++; if (overflow !== 1'b0 || drop_cnt !== 2'd0)
            begin n_fail++; $display("FAIL clr_alone: got ovf=%0b drop=%0d required 0/0", overflow, drop_cnt); end
        clr_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a0 = 32'(8 + i); tick();
            n_checks++; if (drop_cnt !== exp_drop[i])
                begin n_fail++; $display("FAIL drop_sat_%0d: got %0d required %0d", i, drop_cnt, exp_drop[i]); end
        end
        n_checks++; if (count !== 3'd4 || out_data !== 32'd1)
            begin n_fail++; $display("FAIL clr_contents: got count=%0d head=%h required 4/1", count, out_data); end
        $display("test_clr: ovf=%0b drop=%0d", overflow, drop_cnt);
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a0 = 32'h100 + 32'(i); tick();
            n_checks++; if (count !== 3'd1 || out_data !== 32'h100 + 32'(i) || out_ts !== 4'(i))
                begin n_fail++; $display("FAIL b2b_%0d: got count=%0d data=%h ts=%0d required 1/%h/%0d", i, count, out_data, out_ts, 32'h100 + 32'(i), i); end
        end
        tick();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d required 0", count); end
        out_ready = 1'b0;
        $display("test_back_to_back: 6 streamed, count=%0d", count);
    endtask

    task automatic test_ts_wrap_and_midreset();
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        a0 = 32'h10; tick();
        a0 = 32'h11; tick();
        n_checks++; if (count !== 3'd2 || out_data !== 32'h10 || out_ts !== 4'd15)
            begin n_fail++; $display("FAIL wrap_first: got count=%0d data=%h ts=%0d required 2/10/15", count, out_data, out_ts); end
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        n_checks++; if (out_data !== 32'h11 || out_ts !== 4'd0)
            begin n_fail++; $display("FAIL wrap_second: got %h/%0d required 11/0", out_data, out_ts); end
        a0 = 32'h12; tick();
        a0 = 32'h13; tick();
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL pre_rst_count: got %0d required 3", count); end
        rst = 1'b0; tick();
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_ts !== 4'd0)
            begin n_fail++; $display("FAIL midrst: got count=%0d valid=%0b ts=%0d required 0/0/0", count, out_valid, out_ts); end
        rst = 1'b1; a0 = 32'h55; tick();
        n_checks++; if (count !== 3'd1 || out_data !== 32'h55 || out_ts !== 4'd0)
            begin n_fail++; $display("FAIL post_rst_ts: got count=%0d data=%h ts=%0d required 1/55/0", count, out_data, out_ts); end
        $display("test_ts_wrap_and_midreset: head=%h ts=%0d", out_data, out_ts);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; a0 = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        test_reset();
        test_no_change();
        test_single();
        test_overflow();
        test_clr();
        test_back_to_back();
        test_ts_wrap_and_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
